// File: rtl/axi_lite_master_arbiter.sv
// Two-client round-robin arbiter and single-outstanding AXI4-Lite master.
// Each client posts a single-beat read or write on a valid/ready port. The
// arbiter picks one client, runs the transaction on m_axi_*, and returns the
// response to that client as a one-cycle rsp_valid pulse.
//
// Ports:
//   s_axi_aclk, s_axi_aresetn     clock, async active-low reset
//   req_valid/ready/write [1:0]   per-client request handshake and direction
//   req_addr  [2*AW-1:0]          client n address at [n*AW +: AW]
//   req_wdata [2*DW-1:0]          client n write data at [n*DW +: DW]
//   rsp_valid [1:0]               per-client completion pulse
//   rsp_rdata, rsp_resp           read data / AXI response, valid with rsp_valid
//   m_axi_*                       AXI4-Lite master (AW, W, B, AR, R channels)
//
// Optional feature macro: AXI_ARB_ALIGN_CHECK_EN
//   Defined: a granted request with addr[1:0] != 0 is answered with SLVERR
//   one cycle after grant and never reaches the bus.
//
// Timing with an always-ready slave: grant (req_ready) in cycle T, bus valids
// in T+1, rsp_valid in T+4.
module axi_lite_master_arbiter #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                              s_axi_aclk,
    input  logic                              s_axi_aresetn,
    input  logic [1:0]                        req_valid,
    output logic [1:0]                        req_ready,
    input  logic [1:0]                        req_write,
    input  logic [2*C_S_AXI_ADDR_WIDTH-1:0]   req_addr,
    input  logic [2*C_S_AXI_DATA_WIDTH-1:0]   req_wdata,
    output logic [1:0]                        rsp_valid,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                        rsp_resp,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic                              m_axi_awvalid,
    input  logic                              m_axi_awready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                              m_axi_wvalid,
    input  logic                              m_axi_wready,
    input  logic [1:0]                        m_axi_bresp,
    input  logic                              m_axi_bvalid,
    output logic                              m_axi_bready,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic                              m_axi_arvalid,
    input  logic                              m_axi_arready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                        m_axi_rresp,
    input  logic                              m_axi_rvalid,
    output logic                              m_axi_rready
);

    localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
    localparam int unsigned AW = C_S_AXI_ADDR_WIDTH;
    localparam int unsigned SW = C_S_AXI_DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t          state;
    logic            last_grant;
    logic            gnt;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;

    logic            grant_c;
    logic [AW-1:0]   sel_addr_c;
    logic [DW-1:0]   sel_wdata_c;
    logic            sel_write_c;

    // Round-robin pick: a lone requester wins, a tie goes to the client not served last.
    always_comb begin
        grant_c = req_valid[1];
        if (req_valid == 2'b11) begin
            grant_c = ~last_grant;
        end
        sel_addr_c  = grant_c ? req_addr[AW +: AW]  : req_addr[0 +: AW];
        sel_wdata_c = grant_c ? req_wdata[DW +: DW] : req_wdata[0 +: DW];
        sel_write_c = grant_c ? req_write[1]        : req_write[0];
    end

    assign m_axi_awaddr = addr_q;
    assign m_axi_araddr = addr_q;
    assign m_axi_wdata  = wdata_q;
    assign m_axi_wstrb  = {SW{1'b1}};

    // Transaction FSM; req_ready is high only in the first cycle after the
    // grant edge, so it doubles as the "launch the bus valids now" marker.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            gnt           <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            req_ready     <= 2'b00;
            rsp_valid     <= 2'b00;
            rsp_rdata     <= '0;
            rsp_resp      <= 2'b00;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
        end else begin
            req_ready <= 2'b00;
            rsp_valid <= 2'b00;
            case (state)
                IDLE: begin
                    if (req_valid != 2'b00) begin
                        req_ready  <= grant_c ? 2'b10 : 2'b01;
                        gnt        <= grant_c;
                        last_grant <= grant_c;
                        addr_q     <= sel_addr_c;
                        wdata_q    <= sel_wdata_c;
`ifdef AXI_ARB_ALIGN_CHECK_EN
                        if (sel_addr_c[1:0] != 2'b00) begin
                            rsp_resp  <= 2'b10;
                            rsp_rdata <= '0;
                            state     <= DONE;
                        end else
`endif
                        if (sel_write_c) begin
                            state <= WR;
                        end else begin
                            state <= RD_ADDR;
                        end
                    end
                end
                WR: begin
                    if (req_ready != 2'b00) begin
                        m_axi_awvalid <= 1'b1;
                        m_axi_wvalid  <= 1'b1;
                    end else begin
                        // AW and W retire independently; leave once neither is pending.
                        if (m_axi_awready) begin
                            m_axi_awvalid <= 1'b0;
                        end
                        if (m_axi_wready) begin
                            m_axi_wvalid <= 1'b0;
                        end
                        if ((!m_axi_awvalid || m_axi_awready) &&
                            (!m_axi_wvalid  || m_axi_wready)) begin
                            m_axi_bready <= 1'b1;
                            state        <= WR_RESP;
                        end
                    end
                end
                WR_RESP: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        rsp_resp     <= m_axi_bresp;
                        rsp_rdata    <= '0;
                        state        <= DONE;
                    end
                end
                RD_ADDR: begin
                    if (req_ready != 2'b00) begin
                        m_axi_arvalid <= 1'b1;
                    end else if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state         <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (m_axi_rvalid) begin
                        m_axi_rready <= 1'b0;
                        rsp_rdata    <= m_axi_rdata;
                        rsp_resp     <= m_axi_rresp;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    rsp_valid <= gnt ? 2'b10 : 2'b01;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/axi_lite_master_arbiter.md
Name: axi_lite_master_arbiter

Overview:
Two-requester round-robin arbiter and AXI4-Lite master that shares the axi_lite_slave register file between two on-chip clients. The register map is control 0x00, status 0x04 (read-only) and scratch 0x08. Each client issues single-beat read or write requests on a simple valid/ready port. The arbiter serialises them onto one AXI4-Lite master port, one transaction outstanding at a time, and returns read data and response per client. It sits between the client logic and the s_axi_* port of axi_lite_slave; the integrating top ties the slave's prot inputs to 3'b000.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data width of requests and AXI bus
C_S_AXI_ADDR_WIDTH, 4, byte address width of requests and AXI bus

Ports:
s_axi_aclk  in  1  single clock, all logic on rising edge
s_axi_aresetn  in  1  asynchronous, active-low reset
req_valid  in  2  per-client request valid (bit n = client n)
req_ready  out  2  one-cycle grant/accept pulse per client
req_write  in  2  per-client 1=write, 0=read
req_addr  in  2*AW  client n address at [n*AW +: AW]
req_wdata  in  2*DW  client n write data at [n*DW +: DW]
rsp_valid  out  2  one-cycle completion pulse per client
rsp_rdata  out  DW  read data, valid with rsp_valid
rsp_resp  out  2  AXI response code, valid with rsp_valid
m_axi_awaddr  out  AW  write address
m_axi_awvalid  out  1  write address valid
m_axi_awready  in  1  write address ready
m_axi_wdata  out  DW  write data
m_axi_wstrb  out  DW/8  byte strobes, always all-ones
m_axi_wvalid  out  1  write data valid
m_axi_wready  in  1  write data ready
m_axi_bresp  in  2  write response
m_axi_bvalid  in  1  write response valid
m_axi_bready  out  1  write response ready
m_axi_araddr  out  AW  read address
m_axi_arvalid  out  1  read address valid
m_axi_arready  in  1  read address ready
m_axi_rdata  in  DW  read data
m_axi_rresp  in  2  read response
m_axi_rvalid  in  1  read data valid
m_axi_rready  out  1  read data ready

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0, last_grant = 1 so client 0 wins first.
- FSM: IDLE, WR (AW+W), WR_RESP, RD_ADDR, RD_DATA, DONE.
- IDLE arbitration:
  - One valid client: grant it.
  - Both valid: grant ~last_grant.
  - Grant cycle: req_ready[g] = 1 for exactly one cycle. Capture addr, wdata, write and g into internal registers; update last_grant.
  - Next state: WR if write, else RD_ADDR.
- WR: awvalid and wvalid asserted together in the cycle after grant.
  - Each valid drops independently, at the edge after its own handshake.
  - Address and data stay stable while valid.
  - Go to WR_RESP once both have handshaken, including the same-cycle case.
- WR_RESP: bready = 1. On bvalid, latch bresp and go to DONE.
- RD_ADDR: arvalid held until arready, then RD_DATA.
- RD_DATA: rready = 1. On rvalid, latch rdata and rresp, go to DONE.
- DONE: rsp_valid[g] = 1 for one cycle, then IDLE.
  - rsp_rdata holds the last read data until the next read completes; it is 0 after a write.
- Requests present in DONE are arbitrated in the following IDLE cycle. Minimum request-to-request spacing is 1 idle cycle.
- Latency with an always-ready slave:
  - Write: grant at T, rsp_valid at T+4.
  - Read: grant at T, rsp_valid at T+4 if the slave returns rvalid the cycle after arready.
- No timeout; the arbiter waits on the slave indefinitely.
- A requester must hold req_valid and its fields stable until req_ready; req_valid dropped early is simply not granted.
- Reset mid-transaction aborts immediately to IDLE with all valids low. The slave is reset by the same signal.

Optional Feature:
AXI_ARB_ALIGN_CHECK_EN:
- Defined: a granted request with addr[1:0] != 2'b00 never reaches the bus. FSM goes IDLE -> DONE with rsp_resp = 2'b10 (SLVERR) and rsp_rdata = 0. Latency is grant + 1.
- Undefined: all addresses are forwarded unchanged.

Test Plan:
- Client 0 writes 0x12345678 to 0x00, then reads 0x00 -> bresp 00, rsp_rdata 0x12345678, rsp_valid on bit 0 only.
- Client 1 reads 0x04 with status_reg_i = 0xDEADBEEF -> rsp_valid[1], rsp_rdata 0xDEADBEEF, rresp 00.
- Both clients request in the same cycle (c0 writes 0xAA55AA55 to 0x08, c1 reads 0x08), repeated 4 times -> grants alternate 0,1,0,1. Reads after c0's write return 0xAA55AA55.
- Slave holds wready low 3 cycles after awready -> awvalid drops after its handshake, wvalid held with stable data, exactly one write reaches control_reg_o.
- Reset asserted during RD_DATA -> all m_axi valids and ready low immediately, no rsp_valid. After release, client 0 wins first.
- With AXI_ARB_ALIGN_CHECK_EN defined, write to 0x06 -> rsp_resp 10 one cycle after grant, no awvalid/wvalid, scratch unchanged.
